peripheral_uart_receiver_wb: RTL

PERIPHERAL_UART_RECEIVER_WB -- requirements
Module: peripheral_uart_receiver_wb

---
 rtl/peripheral_uart_pkg.sv | 32 +++
 rtl/peripheral_uart_rfifo_wb.sv | 81 ++++++++
 rtl/peripheral_uart_receiver_wb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/peripheral_uart_pkg.sv
// Shared UART receiver definitions: line-control bit positions, RX state
// encodings, FIFO geometry and the parity check helper.
package peripheral_uart_pkg;

    localparam int UART_FIFO_COUNTER_W = 5;
    localparam int UART_LC_PE          = 3;
    localparam int UART_LC_EP          = 4;
    localparam int UART_LC_SP          = 5;
    localparam int RX_ENTRY_W          = 11;

    typedef enum logic [2:0] {
        r_idle   = 3'd0,
        r_start  = 3'd1,
        r_data   = 3'd2,
        r_parity = 3'd3,
        r_stop   = 3'd4,
        r_push   = 3'd5
    } rx_state_e;

    // Stick parity forces the bit to ~EP; otherwise data^bit must be odd (EP=0) or even (EP=1).
    function automatic logic parity_error(input logic [7:0] data, input logic par_bit,
                                          input logic ep, input logic sp);
        logic x;
        x = (^data) ^ par_bit;
        if (sp) begin
            parity_error = (par_bit != ~ep);
        end else begin
            parity_error = ep ? x : ~x;
        end
    endfunction

endpackage

// File: rtl/peripheral_uart_rfifo_wb.sv
// First-word fall-through receive FIFO with sticky overrun flag.
module peripheral_uart_rfifo_wb
    import peripheral_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic [RX_ENTRY_W-1:0]          data_in,
    output logic [RX_ENTRY_W-1:0]          data_out,
    input  logic                           push,
    input  logic                           pop,
    output logic                           overrun,
    output logic [UART_FIFO_COUNTER_W-1:0] count,
    input  logic                           fifo_reset,
    input  logic                           reset_status
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [UART_FIFO_COUNTER_W-1:0] DEPTH_C = UART_FIFO_COUNTER_W'(DEPTH);

    logic [RX_ENTRY_W-1:0]          mem_r [DEPTH];
    logic [AW-1:0]                  wr_ptr_r;
    logic [AW-1:0]                  rd_ptr_r;
    logic [UART_FIFO_COUNTER_W-1:0] count_r;
    logic                           overrun_r;
    logic                           full_s;
    logic                           empty_s;
    logic                           pop_ok_s;
    logic                           push_ok_s;
    logic                           overflow_s;

    // A pop on a full FIFO frees the slot the simultaneous push writes into.
    assign full_s     = (count_r == DEPTH_C);
    assign empty_s    = (count_r == {UART_FIFO_COUNTER_W{1'b0}});
    assign pop_ok_s   = pop & ~empty_s;
    assign push_ok_s  = push & (~full_s | pop_ok_s);
    assign overflow_s = push & full_s & ~pop_ok_s;

    // Pointer and occupancy tracking, flushable by fifo_reset.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {UART_FIFO_COUNTER_W{1'b0}};
        end else if (fifo_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {UART_FIFO_COUNTER_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + UART_FIFO_COUNTER_W'(1);
                2'b01:   count_r <= count_r - UART_FIFO_COUNTER_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push_ok_s && !fifo_reset) mem_r[wr_ptr_r] <= data_in;
    end

    // Sticky overrun; a fresh drop in the same cycle as the clear wins.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) overrun_r <= 1'b0;
        else          overrun_r <= (overrun_r & ~reset_status) | overflow_s;
    end

    // Head entry, forced to zero when nothing is stored.
    always_comb begin
        if (empty_s) data_out = {RX_ENTRY_W{1'b0}};
        else         data_out = mem_r[rd_ptr_r];
    end

    assign overrun = overrun_r;
    assign count   = count_r;

endmodule

// File: rtl/peripheral_uart_receiver_wb.sv
// UART receive path: input synchronizer, 16x-oversampling frame FSM and
// receive FIFO holding {data, parity_err, framing_err, break}.
module peripheral_uart_receiver_wb
    import peripheral_uart_pkg::*;
#(
    parameter int RF_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic [7:0]                     lcr,
    input  logic                           enable,
    input  logic                           srx_pad_i,
    input  logic                           rf_pop,
    input  logic                           rx_reset,
    input  logic                           lsr_mask,
    output logic [RX_ENTRY_W-1:0]          rf_data_out,
    output logic [UART_FIFO_COUNTER_W-1:0] rf_count,
    output logic                           rf_overrun,
    output logic [2:0]                     rstate
);

    rx_state_e   state_r,       state_n;
    logic [3:0]  counter_r,     counter_n;
    logic [2:0]  bit_cnt_r,     bit_cnt_n;
    logic [7:0]  data_r,        data_n;
    logic        perr_r,        perr_n;
    logic        ferr_r,        ferr_n;
    logic        brk_r,         brk_n;
    logic        wait_high_r,   wait_high_n;
    logic        sync1_r;
    logic        srx_s;
    logic        push_s;
    logic [2:0]  wlen_m1_s;
    logic [2:0]  bit_idx_s;
    logic        unused_lcr_s;

    assign wlen_m1_s    = {1'b1, lcr[1:0]};
    assign bit_idx_s    = wlen_m1_s - bit_cnt_r;
    assign unused_lcr_s = ^{lcr[7:6], lcr[2]};

    // Two-flop synchronizer, idling at the line's mark level.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_r <= 1'b1;
            srx_s   <= 1'b1;
        end else begin
            sync1_r <= srx_pad_i;
            srx_s   <= sync1_r;
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= r_idle;
            counter_r   <= 4'd0;
            bit_cnt_r   <= 3'd0;
            data_r      <= 8'h00;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            brk_r       <= 1'b0;
            wait_high_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            counter_r   <= counter_n;
            bit_cnt_r   <= bit_cnt_n;
            data_r      <= data_n;
            perr_r      <= perr_n;
            ferr_r      <= ferr_n;
            brk_r       <= brk_n;
            wait_high_r <= wait_high_n;
        end
    end

    // Next-state logic; every transition is gated by the 16x baud tick.
    always_comb begin
        state_n     = state_r;
        counter_n   = counter_r;
        bit_cnt_n   = bit_cnt_r;
        data_n      = data_r;
        perr_n      = perr_r;
        ferr_n      = ferr_r;
        brk_n       = brk_r;
        wait_high_n = wait_high_r;
        push_s      = 1'b0;
        if (enable) begin
            case (state_r)
                r_idle: begin
                    if (wait_high_r) begin
                        wait_high_n = ~srx_s;
                    end else if (!srx_s) begin
                        counter_n = 4'd7;
                        state_n   = r_start;
                    end else begin
                        state_n = r_idle;
                    end
                end
                r_start: begin
                    if (counter_r != 4'd0) begin
                        counter_n = counter_r - 4'd1;
                    end else if (srx_s) begin
                        state_n = r_idle;
                    end else begin
                        counter_n = 4'd15;
                        bit_cnt_n = wlen_m1_s;
                        data_n    = 8'h00;
                        perr_n    = 1'b0;
                        ferr_n    = 1'b0;
                        brk_n     = 1'b0;
                        state_n   = r_data;
                    end
                end
                r_data: begin
                    if (counter_r != 4'd0) begin
                        counter_n = counter_r - 4'd1;
                    end else begin
                        data_n[bit_idx_s] = srx_s;
                        counter_n         = 4'd15;
                        if (bit_cnt_r == 3'd0) begin
                            state_n = lcr[UART_LC_PE] ? r_parity : r_stop;
                        end else begin
                            bit_cnt_n = bit_cnt_r - 3'd1;
                        end
                    end
                end
                r_parity: begin
                    if (counter_r != 4'd0) begin
                        counter_n = counter_r - 4'd1;
                    end else begin
                        perr_n    = parity_error(data_r, srx_s, lcr[UART_LC_EP], lcr[UART_LC_SP]);
                        counter_n = 4'd15;
                        state_n   = r_stop;
                    end
                end
                r_stop: begin
                    if (counter_r != 4'd0) begin
                        counter_n = counter_r - 4'd1;
                    end else begin
                        ferr_n  = ~srx_s;
                        brk_n   = ~srx_s & (data_r == 8'h00);
                        state_n = r_push;
                    end
                end
                r_push: begin
                    push_s      = 1'b1;
                    wait_high_n = ferr_r;
                    state_n     = r_idle;
                end
                default: begin
                    state_n = r_idle;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    peripheral_uart_rfifo_wb #(
        .DEPTH        (RF_DEPTH)
    ) u_rfifo (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .data_in      ({data_r, perr_r, ferr_r, brk_r}),
        .data_out     (rf_data_out),
        .push         (push_s),
        .pop          (rf_pop),
        .overrun      (rf_overrun),
        .count        (rf_count),
        .fifo_reset   (rx_reset),
        .reset_status (lsr_mask)
    );

    assign rstate = state_r;

endmodule
